// File: rtl/ramp_seq_pkg.sv
// ramp_seq_pkg: shared state encoding, fault codes and counter widths for ramp_sequencer
// No ports.
package ramp_seq_pkg;
    localparam int SIDX_W = 15;
    localparam int RIDX_W = 16;
    localparam int CNT_W  = 32;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_CONFIG  = 7'b0000010,
        S_ARM     = 7'b0000100,
        S_SETTLE  = 7'b0001000,
        S_ACQUIRE = 7'b0010000,
        S_DONE    = 7'b0100000,
        S_FAULT   = 7'b1000000
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_CFG  = 2'b01;
    localparam logic [1:0] FC_RAMP = 2'b10;
    localparam logic [1:0] FC_OVR  = 2'b11;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop level synchronizer
// Ports: clk, rst (sync, active high), i_d async level in, o_q synchronized level out.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_ff;

    always_ff @(posedge clk) begin
        if (rst) r_ff <= '0;
        else     r_ff <= {r_ff[0], i_d};
    end

    assign o_q = r_ff[1];
endmodule

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: FMCW acquisition sequencer around the ADF4158 controller
// Ports: clk, rst (sync, active high); start/stop/err_clr control pulses; num_ramps frame length
// (0 = continuous); adf_configure/adf_config_done configure handshake; adf_ramp_start ramp pulse;
// acq_en/sample_stb/sample_idx acquisition window; ramp_idx/ramp_end/frame_done progress;
// busy/fault/fault_code status. All outputs are registered.
module ramp_sequencer
    import ramp_seq_pkg::*;
#(
    parameter int SAMPLES_PER_RAMP = 20000,
    parameter int SAMPLE_DIV       = 1,
    parameter int SETTLE_CYCLES    = 400,
    parameter int RAMP_TIMEOUT     = 200000,
    parameter int CFG_TIMEOUT      = 4000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              err_clr,
    input  logic [RIDX_W-1:0] num_ramps,
    output logic              adf_configure,
    input  logic              adf_config_done,
    input  logic              adf_ramp_start,
    output logic              acq_en,
    output logic              sample_stb,
    output logic [SIDX_W-1:0] sample_idx,
    output logic [RIDX_W-1:0] ramp_idx,
    output logic              ramp_end,
    output logic              frame_done,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code
);
    localparam logic W_SETTLE = SETTLE_CYCLES != 0;

    state_t            r_state;
    logic [CNT_W-1:0]  r_tmo;
    logic [RIDX_W-1:0] r_num, r_ridx;
    logic [SIDX_W-1:0] r_sidx;
    logic              r_cfgd, r_stop_p, r_cfg, r_acq, r_stb, r_rend, r_fdone, r_busy, r_fault;
    logic [1:0]        r_fcode;

    logic              w_cfg_done, w_tick, w_last, w_stop_p, w_frame_end;
    logic [RIDX_W-1:0] w_ridx_nx;
    logic [1:0]        w_fc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (adf_config_done),
        .o_q (w_cfg_done)
    );

    // r_tmo is the state timer in CONFIG/ARM/SETTLE and the sample divider in ACQUIRE
    assign w_tick      = r_tmo == CNT_W'(SAMPLE_DIV - 1);
    assign w_last      = r_sidx == SIDX_W'(SAMPLES_PER_RAMP - 1);
    assign w_stop_p    = r_stop_p | stop;
    assign w_ridx_nx   = r_ridx + RIDX_W'(1);
    assign w_frame_end = (r_num != '0) && (w_ridx_nx == r_num);

    // fault takes priority over every other transition of the current state
    always_comb
        w_fc = (r_state == S_CONFIG && !w_cfg_done && r_tmo == CNT_W'(CFG_TIMEOUT - 1)) ? FC_CFG :
               (r_state == S_ARM && !stop && !adf_ramp_start &&
                r_tmo == CNT_W'(RAMP_TIMEOUT - 1))                                   ? FC_RAMP :
               ((r_state == S_SETTLE || r_state == S_ACQUIRE) && adf_ramp_start)     ? FC_OVR :
                                                                                       FC_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tmo    <= '0;
            r_num    <= '0;
            r_ridx   <= '0;
            r_sidx   <= '0;
            r_cfgd   <= 1'b0;
            r_stop_p <= 1'b0;
            r_cfg    <= 1'b0;
            r_acq    <= 1'b0;
            r_stb    <= 1'b0;
            r_rend   <= 1'b0;
            r_fdone  <= 1'b0;
            r_busy   <= 1'b0;
            r_fault  <= 1'b0;
            r_fcode  <= FC_NONE;
        end else begin
            r_stb   <= 1'b0;
            r_rend  <= 1'b0;
            r_fdone <= 1'b0;
            r_tmo   <= r_tmo + CNT_W'(1);
            if (w_fc != FC_NONE) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
                r_fcode <= w_fc;
                r_acq   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_stop_p <= 1'b0;
                        if (start && !stop) begin
                            r_num   <= num_ramps;
                            r_ridx  <= '0;
                            r_tmo   <= '0;
                            r_busy  <= 1'b1;
                            r_cfg   <= 1'b1;
                            r_state <= r_cfgd ? S_ARM : S_CONFIG;
                        end
                    end
                    S_CONFIG: if (w_cfg_done) begin
                        r_cfgd  <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= S_ARM;
                    end
                    S_ARM: if (stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (adf_ramp_start) begin
                        r_tmo   <= '0;
                        r_sidx  <= '0;
                        r_acq   <= !W_SETTLE;
                        r_stb   <= !W_SETTLE;
                        r_state <= W_SETTLE ? S_SETTLE : S_ACQUIRE;
                    end
                    S_SETTLE: begin
                        r_stop_p <= w_stop_p;
                        if (r_tmo == CNT_W'(SETTLE_CYCLES - 1)) begin
                            r_tmo   <= '0;
                            r_sidx  <= '0;
                            r_acq   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_state <= S_ACQUIRE;
                        end
                    end
                    S_ACQUIRE: begin
                        r_stop_p <= w_stop_p;
                        if (w_tick) begin
                            r_tmo <= '0;
                            if (w_last) begin
                                r_acq   <= 1'b0;
                                r_rend  <= 1'b1;
                                r_ridx  <= w_ridx_nx;
                                r_state <= w_frame_end ? S_DONE : w_stop_p ? S_IDLE : S_ARM;
                                r_busy  <= w_frame_end || !w_stop_p;
                            end else begin
                                r_sidx <= r_sidx + SIDX_W'(1);
                                r_stb  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_fdone <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_FAULT: if (err_clr) begin
                        r_fault <= 1'b0;
                        r_fcode <= FC_NONE;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign adf_configure = r_cfg;
    assign acq_en        = r_acq;
    assign sample_stb    = r_stb;
    assign sample_idx    = r_sidx;
    assign ramp_idx      = r_ridx;
    assign ramp_end      = r_rend;
    assign frame_done    = r_fdone;
    assign busy          = r_busy;
    assign fault         = r_fault;
    assign fault_code    = r_fcode;
endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: randomized self-checking bench for ramp_sequencer (two parameter sets)
module tb_ramp_sequencer;
    localparam int N = 8;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, err_clr = 1'b0;
    logic        cfg_done = 1'b0, ramp_start = 1'b0;
    logic [15:0] num_ramps = '0;
    logic [1:0]  cfg_o, acq, stb, rend, fdone, busy, flt;
    logic [14:0] sidx [2];
    logic [15:0] ridx [2];
    logic [1:0]  fcode [2];
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    ramp_sequencer #(.SAMPLES_PER_RAMP(N), .SAMPLE_DIV(2), .SETTLE_CYCLES(4),
                     .RAMP_TIMEOUT(100), .CFG_TIMEOUT(50)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .err_clr(err_clr),
        .num_ramps(num_ramps), .adf_configure(cfg_o[0]), .adf_config_done(cfg_done),
        .adf_ramp_start(ramp_start), .acq_en(acq[0]), .sample_stb(stb[0]),
        .sample_idx(sidx[0]), .ramp_idx(ridx[0]), .ramp_end(rend[0]),
        .frame_done(fdone[0]), .busy(busy[0]), .fault(flt[0]), .fault_code(fcode[0])
    );

    ramp_sequencer #(.SAMPLES_PER_RAMP(N), .SAMPLE_DIV(1), .SETTLE_CYCLES(0),
                     .RAMP_TIMEOUT(100), .CFG_TIMEOUT(50)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .err_clr(err_clr),
        .num_ramps(num_ramps), .adf_configure(cfg_o[1]), .adf_config_done(cfg_done),
        .adf_ramp_start(ramp_start), .acq_en(acq[1]), .sample_stb(stb[1]),
        .sample_idx(sidx[1]), .ramp_idx(ridx[1]), .ramp_end(rend[1]),
        .frame_done(fdone[1]), .busy(busy[1]), .fault(flt[1]), .fault_code(fcode[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; stop = 1'b0; err_clr = 1'b0;
        ramp_start = 1'b0; cfg_done = 1'b0; num_ramps = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; ramp_start = 1'b1; cfg_done = 1'b1;
        tick;
        tick;
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({cfg_o[u], acq[u], stb[u], rend[u], fdone[u], busy[u], flt[u]} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_flags u=%0d got=%b exp=0", u,
                         {cfg_o[u], acq[u], stb[u], rend[u], fdone[u], busy[u], flt[u]});
            end
            n_checks++;
            if ({fcode[u], sidx[u], ridx[u]} !== 33'b0) begin
                n_fail++;
                $display("FAIL reset_values u=%0d got code=%0d sidx=%0d ridx=%0d exp=0",
                         u, fcode[u], sidx[u], ridx[u]);
            end
        end
        rst = 1'b0; start = 1'b0; ramp_start = 1'b0; cfg_done = 1'b0;
    endtask

    // Expected outputs derived from ramp-pulse times: window opens SETTLE cycles after the
    // pulse is seen, lasts N*DIV cycles, ramp_end follows it.
    task automatic run_frame(input int u, input int nr, input bit cfgd, input int stop_ramp);
        int st, dv, tot, cfg_at, p, last, stop_c, off, e_idx, e_ridx;
        int ps[4], rs[4], re[4];
        logic e_acq, e_stb, e_rend, e_fd, e_busy, e_cfg;
        st = (u == 0) ? 4 : 0;
        dv = (u == 0) ? 2 : 1;
        tot = (nr > 0) ? nr : stop_ramp + 1;
        cfg_at = int'($urandom_range(3, 15));
        p = cfgd ? 1 : cfg_at + 3 + int'($urandom_range(0, 20));
        for (int k = 0; k < tot; k++) begin
            ps[k] = p;
            rs[k] = p + 1;
            re[k] = rs[k] + st + N * dv;
            p = re[k] + int'($urandom_range(0, 40));
        end
        last = re[tot-1];
        stop_c = (stop_ramp >= 0) ? rs[stop_ramp] + st + 3 * dv : -1;
        num_ramps = 16'(nr);
        for (int c = 0; c <= last + 3; c++) begin
            start = (c == 0);
            stop = (c == stop_c);
            if (!cfgd && c == cfg_at) cfg_done = 1'b1;
            ramp_start = 1'b0;
            e_acq = 1'b0; e_stb = 1'b0; e_rend = 1'b0; e_idx = 0; e_ridx = 0;
            for (int k = 0; k < tot; k++) begin
                if (ps[k] == c) ramp_start = 1'b1;
                off = c - rs[k] - st;
                if (off >= 0 && off < N * dv) begin
                    e_acq = 1'b1;
                    e_stb = (off % dv) == 0;
                    e_idx = off / dv;
                end
                if (off >= N * dv) e_ridx++;
                if (off == N * dv) e_rend = 1'b1;
            end
            e_fd = (nr > 0) && (c == last + 1);
            e_busy = (c >= 1) && ((nr > 0) ? c <= last : c < last);
            e_cfg = cfgd || c >= 1;
            n_checks++;
            if (acq[u] !== e_acq) begin
                n_fail++; $display("FAIL acq_en u=%0d c=%0d got=%b exp=%b", u, c, acq[u], e_acq);
            end
            n_checks++;
            if (stb[u] !== e_stb) begin
                n_fail++; $display("FAIL sample_stb u=%0d c=%0d got=%b exp=%b", u, c, stb[u], e_stb);
            end
            n_checks++;
            if (rend[u] !== e_rend) begin
                n_fail++; $display("FAIL ramp_end u=%0d c=%0d got=%b exp=%b", u, c, rend[u], e_rend);
            end
            n_checks++;
            if (fdone[u] !== e_fd) begin
                n_fail++; $display("FAIL frame_done u=%0d c=%0d got=%b exp=%b", u, c, fdone[u], e_fd);
            end
            n_checks++;
            if (busy[u] !== e_busy) begin
                n_fail++; $display("FAIL busy u=%0d c=%0d got=%b exp=%b", u, c, busy[u], e_busy);
            end
            n_checks++;
            if (cfg_o[u] !== e_cfg || flt[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_fault u=%0d c=%0d got cfg=%b fault=%b exp cfg=%b fault=0",
                         u, c, cfg_o[u], flt[u], e_cfg);
            end
            if (e_stb) begin
                n_checks++;
                if (sidx[u] !== 15'(e_idx)) begin
                    n_fail++; $display("FAIL sample_idx u=%0d c=%0d got=%0d exp=%0d", u, c, sidx[u], e_idx);
                end
            end
            if (c >= 1) begin
                n_checks++;
                if (ridx[u] !== 16'(e_ridx)) begin
                    n_fail++; $display("FAIL ramp_idx u=%0d c=%0d got=%0d exp=%0d", u, c, ridx[u], e_ridx);
                end
            end
            tick;
        end
        start = 1'b0; stop = 1'b0; ramp_start = 1'b0;
    endtask

    task automatic test_frame;
        do_reset;
        run_frame(0, 2, 1'b0, -1);
        repeat (2) run_frame(0, int'($urandom_range(1, 3)), 1'b1, -1);
    endtask

    task automatic test_settle0;
        do_reset;
        run_frame(1, 1, 1'b0, -1);
        run_frame(1, 2, 1'b1, -1);
    endtask

    task automatic test_stop_continuous;
        do_reset;
        run_frame(0, 0, 1'b0, 1);
        run_frame(0, 1, 1'b1, -1);
    endtask

    task automatic test_cfg_timeout;
        do_reset;
        num_ramps = 16'd1;
        for (int c = 0; c <= 55; c++) begin
            start = (c == 0);
            err_clr = (c == 52);
            if (c == 50) begin
                n_checks++;
                if (flt[0] !== 1'b0 || cfg_o[0] !== 1'b1) begin
                    n_fail++; $display("FAIL cfg_pre_timeout got fault=%b cfg=%b exp fault=0 cfg=1", flt[0], cfg_o[0]);
                end
            end
            if (c == 51) begin
                n_checks++;
                if (flt[0] !== 1'b1 || fcode[0] !== 2'b01 || busy[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cfg_timeout got fault=%b code=%b busy=%b exp 1/01/1", flt[0], fcode[0], busy[0]);
                end
            end
            if (c == 53) begin
                n_checks++;
                if (flt[0] !== 1'b0 || fcode[0] !== 2'b00 || busy[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cfg_err_clr got fault=%b code=%b busy=%b exp 0/00/0", flt[0], fcode[0], busy[0]);
                end
            end
            tick;
        end
        start = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_ramp_timeout;
        int cfg_at, arm;
        do_reset;
        num_ramps = 16'd1;
        cfg_at = int'($urandom_range(3, 15));
        arm = cfg_at + 3;
        for (int c = 0; c <= arm + 105; c++) begin
            start = (c == 0) || (c == arm + 101);
            err_clr = (c == arm + 102);
            if (c == cfg_at) cfg_done = 1'b1;
            if (c == arm + 99) begin
                n_checks++;
                if (flt[0] !== 1'b0) begin
                    n_fail++; $display("FAIL ramp_pre_timeout got fault=%b exp=0", flt[0]);
                end
            end
            if (c == arm + 100) begin
                n_checks++;
                if (flt[0] !== 1'b1 || fcode[0] !== 2'b10 || acq[0] !== 1'b0 || busy[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ramp_timeout got fault=%b code=%b acq=%b busy=%b exp 1/10/0/1",
                             flt[0], fcode[0], acq[0], busy[0]);
                end
            end
            if (c == arm + 102) begin
                n_checks++;
                if (flt[0] !== 1'b1 || fcode[0] !== 2'b10) begin
                    n_fail++; $display("FAIL fault_ignores_start got fault=%b code=%b exp 1/10", flt[0], fcode[0]);
                end
            end
            if (c == arm + 103) begin
                n_checks++;
                if (flt[0] !== 1'b0 || fcode[0] !== 2'b00 || busy[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ramp_err_clr got fault=%b code=%b busy=%b exp 0/00/0", flt[0], fcode[0], busy[0]);
                end
            end
            tick;
        end
        start = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_overrun;
        int cfg_at, p, e;
        do_reset;
        num_ramps = 16'd2;
        cfg_at = int'($urandom_range(3, 15));
        p = cfg_at + 3 + int'($urandom_range(1, 20));
        e = p + 5;
        for (int c = 0; c <= e + 25; c++) begin
            start = (c == 0);
            if (c == cfg_at) cfg_done = 1'b1;
            ramp_start = (c == p) || (c == e + 5);
            if (c == e + 5) begin
                n_checks++;
                if (acq[0] !== 1'b1 || flt[0] !== 1'b0) begin
                    n_fail++; $display("FAIL overrun_pre got acq=%b fault=%b exp 1/0", acq[0], flt[0]);
                end
            end
            if (c == e + 6) begin
                n_checks++;
                if (flt[0] !== 1'b1 || fcode[0] !== 2'b11 || acq[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL overrun got fault=%b code=%b acq=%b exp 1/11/0", flt[0], fcode[0], acq[0]);
                end
            end
            n_checks++;
            if (rend[0] !== 1'b0) begin
                n_fail++; $display("FAIL overrun_ramp_end c=%0d got=%b exp=0", c, rend[0]);
            end
            tick;
        end
        n_checks++;
        if (ridx[0] !== 16'd0) begin
            n_fail++; $display("FAIL overrun_ramp_idx got=%0d exp=0", ridx[0]);
        end
        start = 1'b0; ramp_start = 1'b0;
    endtask

    task automatic test_reset_mid;
        int cfg_at, p, e;
        do_reset;
        num_ramps = 16'd1;
        cfg_at = int'($urandom_range(3, 15));
        p = cfg_at + 3 + int'($urandom_range(1, 20));
        e = p + 5;
        for (int c = 0; c <= e + 3; c++) begin
            start = (c == 0);
            if (c == cfg_at) cfg_done = 1'b1;
            ramp_start = (c == p);
            if (c == e + 3) begin
                n_checks++;
                if (acq[0] !== 1'b1) begin
                    n_fail++; $display("FAIL mid_acquire got acq=%b exp=1", acq[0]);
                end
                rst = 1'b1;
            end
            tick;
        end
        n_checks++;
        if ({cfg_o[0], acq[0], stb[0], rend[0], fdone[0], busy[0], flt[0], fcode[0], sidx[0], ridx[0]} !== 40'b0) begin
            n_fail++;
            $display("FAIL reset_mid got cfg=%b acq=%b stb=%b busy=%b sidx=%0d exp all 0",
                     cfg_o[0], acq[0], stb[0], busy[0], sidx[0]);
        end
        rst = 1'b0; cfg_done = 1'b0; start = 1'b1; ramp_start = 1'b0;
        tick;
        start = 1'b0;
        ramp_start = 1'b1;
        n_checks++;
        if (cfg_o[0] !== 1'b1 || busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL reconfig got cfg=%b busy=%b exp 1/1", cfg_o[0], busy[0]);
        end
        tick;
        ramp_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if (acq[0] !== 1'b0 || busy[0] !== 1'b1) begin
                n_fail++; $display("FAIL config_ignores_ramp c=%0d got acq=%b busy=%b exp 0/1", c, acq[0], busy[0]);
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_settle0;
        test_stop_continuous;
        test_cfg_timeout;
        test_ramp_timeout;
        test_overrun;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
